// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer that drives an external modular multiplier.
// Optional macro MOD_EXP_SKIP_LEADING_ZEROS_EN starts the bit scan at the exponent's highest set bit.
module mod_exp_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_mod,
  input  logic [WIDTH-1:0] mul_result,
  input  logic             mul_done
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RED_REQ  = 4'd1,
    RED_WAIT = 4'd2,
    SQ_REQ   = 4'd3,
    SQ_WAIT  = 4'd4,
    MUL_REQ  = 4'd5,
    MUL_WAIT = 4'd6,
    NEXT     = 4'd7,
    FIN      = 4'd8
  } state_t;

  state_t state_r, state_n;
  logic [WIDTH-1:0] base_r, base_n, exp_r, exp_n, acc_r, acc_n, rbase_r, rbase_n;
  logic [IW-1:0]    idx_r, idx_n;
  logic [WIDTH-1:0] result_r, result_n, mul_a_r, mul_a_n, mul_b_r, mul_b_n, mul_mod_r, mul_mod_n;
  logic             done_r, done_n, busy_r, busy_n, err_r, err_n, mul_start_r, mul_start_n;
  logic             rsp_ok;

`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
  function automatic logic [IW-1:0] msb_index(input logic [WIDTH-1:0] v);
    msb_index = {IW{1'b0}};
    for (int k = 0; k < WIDTH; k++) begin
      if (v[k]) msb_index = k[IW-1:0];
    end
  endfunction
`endif

  // A response can never land in the same cycle as its own request pulse.
  assign rsp_ok = mul_done && !mul_start_r;

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    state_n     = state_r;
    base_n      = base_r;
    exp_n       = exp_r;
    acc_n       = acc_r;
    rbase_n     = rbase_r;
    idx_n       = idx_r;
    result_n    = result_r;
    mul_a_n     = mul_a_r;
    mul_b_n     = mul_b_r;
    mul_mod_n   = mul_mod_r;
    busy_n      = busy_r;
    err_n       = err_r;
    done_n      = 1'b0;
    mul_start_n = 1'b0;
    case (state_r)
      IDLE: begin
        busy_n = start;
        if (start) begin
          base_n    = base;
          exp_n     = exponent;
          mul_mod_n = modulus;
          idx_n     = IDX_TOP;
          err_n     = 1'b0;
          if (modulus == ZERO || modulus == ONE) begin
            acc_n   = ZERO;
            state_n = FIN;
          end else begin
            acc_n   = ONE;
            state_n = RED_REQ;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RED_REQ: begin
        mul_start_n = 1'b1;
        mul_a_n     = base_r;
        mul_b_n     = ONE;
        state_n     = RED_WAIT;
      end
      RED_WAIT: begin
        if (rsp_ok) begin
          rbase_n = mul_result;
          if (exp_r == ZERO) begin
            state_n = FIN;
          end else begin
`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
            idx_n = msb_index(exp_r);
`else
            idx_n = IDX_TOP;
`endif
            state_n = SQ_REQ;
          end
        end else begin
          state_n = RED_WAIT;
        end
      end
      SQ_REQ: begin
        mul_start_n = 1'b1;
        mul_a_n     = acc_r;
        mul_b_n     = acc_r;
        state_n     = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (rsp_ok) begin
          acc_n   = mul_result;
          state_n = exp_r[idx_r] ? MUL_REQ : NEXT;
        end else begin
          state_n = SQ_WAIT;
        end
      end
      MUL_REQ: begin
        mul_start_n = 1'b1;
        mul_a_n     = acc_r;
        mul_b_n     = rbase_r;
        state_n     = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (rsp_ok) begin
          acc_n   = mul_result;
          state_n = NEXT;
        end else begin
          state_n = MUL_WAIT;
        end
      end
      NEXT: begin
        if (idx_r == {IW{1'b0}}) begin
          state_n = FIN;
        end else begin
          idx_n   = idx_r - {{(IW-1){1'b0}}, 1'b1};
          state_n = SQ_REQ;
        end
      end
      FIN: begin
        result_n = acc_r;
        done_n   = 1'b1;
        err_n    = (mul_mod_r == ZERO);
        state_n  = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      base_r      <= ZERO;
      exp_r       <= ZERO;
      acc_r       <= ZERO;
      rbase_r     <= ZERO;
      idx_r       <= {IW{1'b0}};
      result_r    <= ZERO;
      mul_a_r     <= ZERO;
      mul_b_r     <= ZERO;
      mul_mod_r   <= ZERO;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      mul_start_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      base_r      <= base_n;
      exp_r       <= exp_n;
      acc_r       <= acc_n;
      rbase_r     <= rbase_n;
      idx_r       <= idx_n;
      result_r    <= result_n;
      mul_a_r     <= mul_a_n;
      mul_b_r     <= mul_b_n;
      mul_mod_r   <= mul_mod_n;
      done_r      <= done_n;
      busy_r      <= busy_n;
      err_r       <= err_n;
      mul_start_r <= mul_start_n;
    end
  end

  assign result    = result_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign err       = err_r;
  assign mul_start = mul_start_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign mul_mod   = mul_mod_r;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl: behavioural multiplier responder plus arithmetic reference model.
// Honors MOD_EXP_SKIP_LEADING_ZEROS_EN when computing the expected request count.
module tb_mod_exp_ctrl;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] base, exponent, modulus;
  logic [15:0] result, mul_a, mul_b, mul_mod, mul_result;
  logic        done, busy, err, mul_start, mul_done;

  int total = 0;
  int bad   = 0;

  mod_exp_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .result(result), .done(done), .busy(busy), .err(err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_mod(mul_mod),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Behavioural modular multiplier with programmable latency.
  int          lat = 1;
  int          pend_cnt = 0;
  logic        pend = 1'b0;
  logic        mul_done_q = 1'b0;
  logic        inj = 1'b0;
  logic [15:0] pa, pb, pm;
  logic [15:0] res_q = 16'd0;
  int          nreq = 0;
  int          overlap = 0;
  logic [15:0] req_a [0:1023];
  logic [15:0] req_b [0:1023];

  assign mul_done   = mul_done_q | inj;
  assign mul_result = res_q;

  always @(posedge clk) begin
    longint unsigned prod;
    mul_done_q <= 1'b0;
    if (mul_start && mul_done) overlap <= overlap + 1;
    if (pend) begin
      if (pend_cnt <= 1) begin
        prod = (longint'(pa) * longint'(pb)) % longint'(pm);
        res_q      <= prod[15:0];
        mul_done_q <= 1'b1;
        pend       <= 1'b0;
        if (busy) begin
          check("operands_stable", {mul_a, mul_b}, {pa, pb});
          check("modulus_stable", {16'd0, mul_mod}, {16'd0, pm});
        end
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
    if (mul_start) begin
      pend     <= 1'b1;
      pend_cnt <= lat;
      pa       <= mul_a;
      pb       <= mul_b;
      pm       <= mul_mod;
      if (nreq < 1024) begin
        req_a[nreq] <= mul_a;
        req_b[nreq] <= mul_b;
      end
      nreq <= nreq + 1;
    end
  end

  function automatic logic [15:0] ref_pow(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
    longint unsigned r, x, mm;
    logic [15:0] ee;
    if (m <= 16'd1) return 16'd0;
    mm = longint'(m);
    r  = 1;
    x  = longint'(b) % mm;
    ee = e;
    while (ee != 16'd0) begin
      if (ee[0]) r = (r * x) % mm;
      x  = (x * x) % mm;
      ee = ee >> 1;
    end
    return r[15:0];
  endfunction

  function automatic int ref_reqs(input logic [15:0] e, input logic [15:0] m);
`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
    int msb;
`endif
    if (m <= 16'd1) return 0;
    if (e == 16'd0) return 1;
`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
    msb = 0;
    for (int k = 0; k < 16; k++) if (e[k]) msb = k;
    return 2 + msb + $countones(e);
`else
    return 17 + $countones(e);
`endif
  endfunction

  task automatic run_exp(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                         input int l, input logic [15:0] exp_res, input bit disturb, input string tag);
    int cyc;
    int n0;
    bit armed;
    bit did_inj;
    lat = l;
    base = b; exponent = e; modulus = m;
    n0 = nreq;
    armed = 1'b0; did_inj = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (inj) inj = 1'b0;
      if (armed) begin inj = 1'b1; armed = 1'b0; end
      if (disturb && !did_inj && mul_done_q) begin armed = 1'b1; did_inj = 1'b1; end
      if (disturb && cyc == 30) begin
        start = 1'b1; base = 16'hBEEF; exponent = 16'h0003; modulus = 16'd0;
      end
      if (disturb && cyc == 31) start = 1'b0;
    end
    inj = 1'b0;
    check({tag, "_no_timeout"}, {31'd0, done}, 32'd1);
    check({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    check({tag, "_err"}, {31'd0, err}, {31'd0, (m == 16'd0)});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    check({tag, "_req_count"}, nreq - n0, ref_reqs(e, m));
  endtask

  initial begin
    int n0;
    int cyc;
    logic [15:0] rb, re, rm;
    reset = 1'b0; start = 1'b0; base = 16'd0; exponent = 16'd0; modulus = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {result, mul_a}, 32'd0);
    check("reset_flags", {done, busy, err, mul_start, mul_b, mul_mod}, 36'd0);
    reset = 1'b1;

    run_exp(16'd4, 16'd13, 16'd497, 3, 16'd445, 1'b0, "t4_13");
    run_exp(16'd65, 16'd17, 16'd3233, 2, 16'd2790, 1'b0, "t65_17");
    n0 = nreq;
    run_exp(16'd500, 16'd1, 16'd497, 1, 16'd3, 1'b0, "t500_1");
    check("first_req_a", {16'd0, req_a[n0]}, 32'd500);
    check("first_req_b", {16'd0, req_b[n0]}, 32'd1);
    run_exp(16'd9, 16'd0, 16'd7, 2, 16'd1, 1'b0, "exp0");
    run_exp(16'd9, 16'd5, 16'd1, 2, 16'd0, 1'b0, "mod1");
    run_exp(16'd9, 16'd5, 16'd0, 2, 16'd0, 1'b0, "mod0");
    run_exp(16'd7, 16'd65535, 16'd65535, 1, ref_pow(16'd7, 16'd65535, 16'd65535), 1'b0, "allones");

    // Reset in SQ_WAIT with a multiplier response still in flight.
    lat = 6;
    base = 16'd3; exponent = 16'hFFFF; modulus = 16'd1001;
    n0 = nreq;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (nreq < n0 + 2 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    check("rst_reach_sq", nreq - n0, 2);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("rst_async_outputs", {result, mul_a, mul_b, mul_mod}, 64'd0);
    check("rst_async_flags", {28'd0, done, busy, err, mul_start}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    n0 = nreq;
    repeat (12) @(posedge clk);
    #1;
    check("rst_idle_outputs", {result, mul_a, mul_b, mul_mod}, 64'd0);
    check("rst_idle_flags", {28'd0, done, busy, err, mul_start}, 32'd0);
    check("rst_no_new_req", nreq - n0, 0);
    run_exp(16'd2, 16'd10, 16'd1000, 2, 16'd24, 1'b0, "after_rst");

    // Start while busy plus a stray mul_done outside any wait state.
    run_exp(16'd4, 16'd13, 16'd497, 3, 16'd445, 1'b1, "disturb");

    for (int t = 0; t < 8; t++) begin
      rb = 16'($urandom_range(0, 65535));
      re = 16'($urandom_range(0, 65535));
      rm = 16'($urandom_range(2, 65535));
      if (t == 0) re = 16'd0;
      if (t == 1) rm = 16'($urandom_range(2, 20));
      run_exp(rb, re, rm, int'($urandom_range(1, 4)), ref_pow(rb, re, rm), 1'b0, $sformatf("rnd%0d", t));
    end

    check("no_start_done_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Modular-exponentiation sequencer for the RSA transmit path. Computes base^exponent mod modulus by left-to-right binary square-and-multiply.
- Does not multiply itself. Acts as the initiator on the modular-multiplier request/response handshake and issues one modular product per request.
- Sits between the key/message registers and the shared modular multiplier.

Parameters:
- WIDTH, 16, operand/exponent/modulus width; must match the attached multiplier.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- base  in  WIDTH  message/base operand, latched on accepted start
- exponent  in  WIDTH  exponent, latched on accepted start
- modulus  in  WIDTH  modulus, latched on accepted start
- result  out  WIDTH  base^exponent mod modulus; held until next accepted start
- done  out  1  one-cycle pulse when result is valid
- busy  out  1  high from the cycle after accepted start through the done cycle
- err  out  1  set with done when modulus==0; cleared on next accepted start
- mul_start  out  1  one-cycle multiply request pulse
- mul_a  out  WIDTH  multiplier operand A
- mul_b  out  WIDTH  multiplier operand B
- mul_mod  out  WIDTH  multiplier modulus (latched modulus)
- mul_result  in  WIDTH  multiplier product mod mul_mod; valid in the mul_done cycle
- mul_done  in  1  one-cycle pulse; completes the outstanding request

Behaviour:
- Reset (reset low, any state, including mid-operation): go to IDLE. result, done, busy, err, mul_start, mul_a, mul_b, mul_mod = 0. Any in-flight mul_done arriving after reset release is ignored in IDLE.
- States: IDLE, RED_REQ, RED_WAIT, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, NEXT, FIN.
- IDLE: on start, latch operands, set acc=1, bit index i=WIDTH-1, clear err.
  - modulus==0: go to FIN with result=0, err=1.
  - modulus==1: go to FIN with result=0.
  - Otherwise go to RED_REQ.
  - start while busy is ignored.
- RED_REQ: pulse mul_start with mul_a=base, mul_b=1. This reduces base below modulus. Go to RED_WAIT.
- RED_WAIT: on mul_done, store mul_result as rbase.
  - exponent==0: go to FIN with result=acc=1.
  - Otherwise go to SQ_REQ.
- SQ_REQ: pulse mul_start with mul_a=mul_b=acc. Go to SQ_WAIT.
- SQ_WAIT: on mul_done, acc=mul_result.
  - exponent[i]=1: go to MUL_REQ.
  - exponent[i]=0: go to NEXT.
- MUL_REQ: pulse mul_start with mul_a=acc, mul_b=rbase. Go to MUL_WAIT.
- MUL_WAIT: on mul_done, acc=mul_result. Go to NEXT.
- NEXT:
  - i==0: go to FIN.
  - Otherwise i=i-1 and go to SQ_REQ.
- FIN: result=acc (or the special value above), done=1 for one cycle, go to IDLE. busy drops the cycle after done.
- Multiplier handshake:
  - mul_a, mul_b and mul_mod are stable from the mul_start cycle until the mul_done cycle inclusive.
  - Exactly one request is outstanding at a time.
  - mul_done outside a *_WAIT state is ignored.
  - mul_start is never high on the same cycle as the mul_done that completes the previous request.
- Latency: any multiplier latency (>=1 cycle) is tolerated; there is no timeout.
- Request count, without the optional feature: 1 + WIDTH + popcount(exponent) when modulus>1 and exponent!=0. This is constant in the exponent's bit positions.

Optional Feature:
- Macro: MOD_EXP_SKIP_LEADING_ZEROS_EN.
- Defined: in RED_WAIT, i is set to the index of the highest set bit of exponent. Squarings for bits above it are not issued. Request count = 1 + (msb_index+1) + popcount(exponent).
- Undefined: all WIDTH bit positions are processed; timing is independent of exponent magnitude.

Test Plan:
- base=4, exponent=13, modulus=497, multiplier latency 3 -> result=445, done one pulse, err=0, 1+16+3=20 mul_start pulses.
- base=65, exponent=17, modulus=3233 -> result=2790. Request count is 19 with the feature off and 8 with MOD_EXP_SKIP_LEADING_ZEROS_EN defined.
- base=500, exponent=1, modulus=497 -> result=3. First request has mul_a=500, mul_b=1.
- exponent=0, modulus=7 -> result=1. modulus=1 -> result=0 with zero mul_start pulses. modulus=0 -> result=0, err=1.
- Pull reset low during SQ_WAIT, then release; late mul_done pulse arrives -> all outputs 0, stays IDLE. A new start (2^10 mod 1000) -> result=24.
- start pulsed while busy, and mul_done injected in an unexpected state -> ignored; in-progress result unchanged and correct.
